firebird7_in_gate1_tessent_data_mux_seq: RTL

// - Multi-channel, sequenced successor of the IJTAG data mux. Sits between functional logic
//   and instrument-controlled data on CHANNELS buses of WIDTH bits.
// - One addressed channel at a time is handed over to IJTAG control. Handover holds the last

---
 rtl/firebird7_in_gate1_tessent_data_mux_pkg.sv | 21 ++
 rtl/firebird7_in_gate1_tessent_data_mux_settle_cnt.sv | 41 ++++
 rtl/firebird7_in_gate1_tessent_data_mux_seq.sv | 133 +++++++++++++
 3 files changed

// File: rtl/firebird7_in_gate1_tessent_data_mux_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// firebird7_in_gate1_tessent_data_mux_pkg : shared types for the sequenced IJTAG data mux
// Revision 1.0
// ---------------------------------------------------------------------------
package firebird7_in_gate1_tessent_data_mux_pkg;

  typedef enum logic [1:0] {
    FUNC     = 2'd0,
    HOLD_IN  = 2'd1,
    IJTAG    = 2'd2,
    HOLD_OUT = 2'd3
  } state_e;

  // Channel select width; a single channel still needs one select bit.
  function automatic int ch_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/firebird7_in_gate1_tessent_data_mux_settle_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// firebird7_in_gate1_tessent_data_mux_settle_cnt : loadable settle down-counter
// Revision 1.0
// ---------------------------------------------------------------------------
module firebird7_in_gate1_tessent_data_mux_settle_cnt #(
  parameter int SETTLE_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(SETTLE_CYCLES - 1);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/firebird7_in_gate1_tessent_data_mux_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// firebird7_in_gate1_tessent_data_mux_seq : multi-channel IJTAG data mux with settled handover
// Revision 1.0
// ---------------------------------------------------------------------------
module firebird7_in_gate1_tessent_data_mux_seq
  import firebird7_in_gate1_tessent_data_mux_pkg::*;
#(
  parameter int WIDTH         = 19,
  parameter int CHANNELS      = 4,
  parameter int SETTLE_CYCLES = 3,
  parameter int CH_W          = ch_w(CHANNELS)
) (
  input  logic                      ijtag_tck,
  input  logic                      ijtag_reset,
  input  logic                      ijtag_select,
  input  logic [CH_W-1:0]           ijtag_channel_sel,
  input  logic [WIDTH-1:0]          ijtag_data_in,
  input  logic                      ijtag_data_valid,
  input  logic [CHANNELS*WIDTH-1:0] functional_data_in,
  output logic [CHANNELS*WIDTH-1:0] data_out,
  output logic                      ijtag_ack,
  output logic                      busy,
  output logic                      sel_error
);

  state_e           state_q, state_d;
  logic [CH_W-1:0]  own_q, own_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic             sel_err;
  logic             chan_ok;
  logic [WIDTH-1:0] func_ch [CHANNELS];

  assign chan_ok = (32'(ijtag_channel_sel) < 32'(CHANNELS));

  firebird7_in_gate1_tessent_data_mux_settle_cnt #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_cnt (
    .clk   (ijtag_tck),
    .rst_n (ijtag_reset),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .zero  (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    own_d    = own_q;
    hold_d   = hold_q;
    shadow_d = shadow_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    sel_err  = 1'b0;
    case (state_q)
      FUNC: begin
        if (ijtag_select) begin
          if (chan_ok) begin
            own_d    = ijtag_channel_sel;
            hold_d   = func_ch[ijtag_channel_sel];
            cnt_load = 1'b1;
            state_d  = HOLD_IN;
          end else begin
            sel_err = 1'b1;
          end
        end
      end
      HOLD_IN: begin
        // Abort wins over completion so a dropped request never reaches IJTAG.
        if (!ijtag_select) begin
          cnt_load = 1'b1;
          state_d  = HOLD_OUT;
        end else if (cnt_zero) begin
          shadow_d = hold_q;
          state_d  = IJTAG;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      IJTAG: begin
        if (ijtag_data_valid) begin
          shadow_d = ijtag_data_in;
        end
        if (!ijtag_select) begin
          hold_d   = ijtag_data_valid ? ijtag_data_in : shadow_q;
          cnt_load = 1'b1;
          state_d  = HOLD_OUT;
        end
      end
      HOLD_OUT: begin
        if (cnt_zero) begin
          state_d = FUNC;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = FUNC;
    endcase
  end

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state_q  <= FUNC;
      own_q    <= '0;
      hold_q   <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
      hold_q   <= hold_d;
      shadow_q <= shadow_d;
    end
  end

  assign ijtag_ack = (state_q == IJTAG);
  assign busy      = (state_q == HOLD_IN) || (state_q == HOLD_OUT);
  assign sel_error = sel_err & ijtag_reset;

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      localparam logic [CH_W-1:0] C_IDX = CH_W'(c);
      logic owned;
      assign func_ch[c] = functional_data_in[c*WIDTH +: WIDTH];
      assign owned      = (state_q != FUNC) && (own_q == C_IDX);
      assign data_out[c*WIDTH +: WIDTH] =
        !owned              ? func_ch[c] :
        (state_q == IJTAG)  ? shadow_q   : hold_q;
    end
  endgenerate

endmodule
`default_nettype wire
